// File: rtl/mem_wb_skid_stage_pkg.sv
// Shared MEM->WB definitions: default widths and the writeback control bundle
// reused by the pipeline-stage registers.
package mem_wb_skid_stage_pkg;

  localparam int WB_DATA_W     = 16;
  localparam int WB_REG_ADDR_W = 5;

  typedef struct packed {
    logic                     reg_write;
    logic                     mem_to_reg;
    logic [WB_REG_ADDR_W-1:0] write_reg;
  } wb_ctrl_t;

endpackage

// File: rtl/mem_wb_skid_stage_skid_buf.sv
// Generic valid/ready/flush pipeline register of width W.
// Two-entry skid buffer with registered ready, or a single register.
module pipe_skid_buf #(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data,
  output logic [1:0]   count
);

  logic head_valid;
  logic skid_valid;
  logic accept;
  logic consume;

  assign dn_valid = head_valid;
  assign accept   = up_valid & up_ready;
  assign consume  = head_valid & dn_ready;
  // skid can only be occupied while head is occupied
  assign count    = {head_valid & skid_valid, head_valid ^ skid_valid};

  generate
    if (SKID_EN) begin : g_skid
      logic [W-1:0] skid_data;

      assign up_ready = ~skid_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          head_valid <= 1'b0;
          skid_valid <= 1'b0;
          dn_data    <= '0;
          skid_data  <= '0;
        end else if (flush) begin
          head_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (skid_valid) begin
          if (consume) begin
            dn_data    <= skid_data;
            skid_valid <= 1'b0;
          end
        end else if (!head_valid || consume) begin
          head_valid <= accept;
          if (accept) dn_data <= up_data;
        end else if (accept) begin
          skid_valid <= 1'b1;
          skid_data  <= up_data;
        end
      end
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign up_ready   = ~head_valid | dn_ready;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          head_valid <= 1'b0;
          dn_data    <= '0;
        end else if (flush) begin
          head_valid <= 1'b0;
        end else if (up_ready) begin
          head_valid <= up_valid;
          if (accept) dn_data <= up_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage: buffers the writeback bundle, selects the writeback
// data and qualifies the register-file write enable.
module mem_wb_skid_stage
  import mem_wb_skid_stage_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int REG_ADDR_W  = WB_REG_ADDR_W,
  parameter bit SKID_EN     = 1'b1,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid_M,
  output logic                  o_ready,
  input  logic                  i_flush,
  input  logic                  i_REGWrite_M,
  input  logic                  i_MEMtoReg_M,
  input  logic [REG_ADDR_W-1:0] i_Write_Reg_M,
  input  logic [DATA_W-1:0]     i_DMEM_out,
  input  logic [DATA_W-1:0]     i_ALU_out,
  output logic                  o_valid_W,
  input  logic                  i_ready,
  output logic                  o_REGWrite_W,
  output logic                  o_MEMtoReg_W,
  output logic [REG_ADDR_W-1:0] o_Write_Reg_W,
  output logic [DATA_W-1:0]     o_DMEM_out,
  output logic [DATA_W-1:0]     o_ALU_out,
  output logic [DATA_W-1:0]     o_wb_data,
  output logic                  o_wb_en,
  output logic [1:0]            o_count
);

  localparam int W = $bits(wb_ctrl_t) + 2 * DATA_W;

  wb_ctrl_t          ctrl_m;
  wb_ctrl_t          ctrl_w;
  logic [DATA_W-1:0] dmem_w;
  logic [DATA_W-1:0] alu_w;
  logic [W-1:0]      data_m;
  logic [W-1:0]      data_w;
  logic              head_valid;
  logic              zero_dst;

  assign ctrl_m = '{reg_write: i_REGWrite_M, mem_to_reg: i_MEMtoReg_M, write_reg: i_Write_Reg_M};
  assign data_m = {ctrl_m, i_DMEM_out, i_ALU_out};

  pipe_skid_buf #(
    .W       (W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (i_flush),
    .up_valid (i_valid_M),
    .up_ready (o_ready),
    .up_data  (data_m),
    .dn_valid (head_valid),
    .dn_ready (i_ready),
    .dn_data  (data_w),
    .count    (o_count)
  );

  assign {ctrl_w, dmem_w, alu_w} = data_w;

  // payload may be stale after a flush, so every head field is masked by valid
  assign o_valid_W     = head_valid;
  assign o_REGWrite_W  = head_valid & ctrl_w.reg_write;
  assign o_MEMtoReg_W  = head_valid & ctrl_w.mem_to_reg;
  assign o_Write_Reg_W = head_valid ? ctrl_w.write_reg : '0;
  assign o_DMEM_out    = head_valid ? dmem_w : '0;
  assign o_ALU_out     = head_valid ? alu_w : '0;
  assign o_wb_data     = o_MEMtoReg_W ? o_DMEM_out : o_ALU_out;

  assign zero_dst = ZERO_REG_RO && (ctrl_w.write_reg == '0);
  assign o_wb_en  = head_valid & i_ready & ~i_flush & ctrl_w.reg_write & ~zero_dst;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: skid (SKID_EN=1) and single-register (SKID_EN=0)
// builds share one input stream, each tracked by a bounded-queue model.
module tb_mem_wb_skid_stage;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [4:0]  wr;
    logic [15:0] dmem;
    logic [15:0] alu;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_m = 1'b0, flush = 1'b0, rdy = 1'b0, rw = 1'b0, m2r = 1'b0;
  logic [4:0]  wr = '0;
  logic [15:0] dmem = '0, alu = '0;

  logic v1, rdy1, rw1, m2r1, wben1;
  logic [4:0]  wr1;
  logic [15:0] dm1, al1, wbd1;
  logic [1:0]  cnt1;
  logic v0, rdy0, rw0, m2r0, wben0;
  logic [4:0]  wr0;
  logic [15:0] dm0, al0, wbd0;
  logic [1:0]  cnt0;

  wire logic [59:0] act1 = {v1, rdy1, cnt1, rw1, m2r1, wr1, dm1, al1, wbd1, wben1};
  wire logic [59:0] act0 = {v0, rdy0, cnt0, rw0, m2r0, wr0, dm0, al0, wbd0, wben0};

  beat_t q1[$];
  beat_t q0[$];
  beat_t nb = '0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_wb_skid_stage #(.DATA_W(16), .REG_ADDR_W(5), .SKID_EN(1'b1), .ZERO_REG_RO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_valid_M(valid_m), .o_ready(rdy1), .i_flush(flush),
    .i_REGWrite_M(rw), .i_MEMtoReg_M(m2r), .i_Write_Reg_M(wr), .i_DMEM_out(dmem), .i_ALU_out(alu),
    .o_valid_W(v1), .i_ready(rdy), .o_REGWrite_W(rw1), .o_MEMtoReg_W(m2r1), .o_Write_Reg_W(wr1),
    .o_DMEM_out(dm1), .o_ALU_out(al1), .o_wb_data(wbd1), .o_wb_en(wben1), .o_count(cnt1));

  mem_wb_skid_stage #(.DATA_W(16), .REG_ADDR_W(5), .SKID_EN(1'b0), .ZERO_REG_RO(1'b1)) dut0 (
    .clk(clk), .rst(rst), .i_valid_M(valid_m), .o_ready(rdy0), .i_flush(flush),
    .i_REGWrite_M(rw), .i_MEMtoReg_M(m2r), .i_Write_Reg_M(wr), .i_DMEM_out(dmem), .i_ALU_out(alu),
    .o_valid_W(v0), .i_ready(rdy), .o_REGWrite_W(rw0), .o_MEMtoReg_W(m2r0), .o_Write_Reg_W(wr0),
    .o_DMEM_out(dm0), .o_ALU_out(al0), .o_wb_data(wbd0), .o_wb_en(wben0), .o_count(cnt0));

  task automatic drive(input logic v, input logic w, input logic m, input logic [4:0] r,
                       input logic [15:0] d, input logic [15:0] a, input logic rd, input logic f);
    valid_m = v; rw = w; m2r = m; wr = r; dmem = d; alu = a; rdy = rd; flush = f;
  endtask

  // Advance one clock edge and apply the same transfer to both models.
  task automatic tick();
    beat_t b;
    logic a1, c1, a0, c0;
    b  = {rw, m2r, wr, dmem, alu};
    a1 = valid_m && (q1.size() < 2);
    c1 = (q1.size() > 0) && rdy;
    a0 = valid_m && (q0.size() == 0 || rdy);
    c0 = (q0.size() > 0) && rdy;
    @(posedge clk);
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (c1) void'(q1.pop_front());
      if (a1) q1.push_back(b);
      if (c0) void'(q0.pop_front());
      if (a0) q0.push_back(b);
    end
    #1;
  endtask

  function automatic logic [59:0] exp_vec(input int sz, input beat_t h, input bit cap2);
    beat_t g;
    logic v, r, en;
    logic [15:0] d;
    v  = (sz > 0);
    g  = v ? h : '0;
    r  = cap2 ? (sz < 2) : (sz == 0 || rdy);
    d  = g.m2r ? g.dmem : g.alu;
    en = v && rdy && !flush && g.rw && (g.wr != 5'd0);
    return {v, r, 2'(sz), g.rw, g.m2r, g.wr, g.dmem, g.alu, d, en};
  endfunction

  task automatic test_reset();
    #3;
    vectors++; if (v1 !== 1'b0 || v0 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b/%b want 0/0", v1, v0); end
    vectors++; if (cnt1 !== 2'd0 || cnt0 !== 2'd0) begin miscompares++; $display("FAIL reset_count: got %0d/%0d want 0/0", cnt1, cnt0); end
    vectors++; if (wbd1 !== 16'h0 || wben1 !== 1'b0) begin miscompares++; $display("FAIL reset_wb: got data=%h en=%b want 0/0", wbd1, wben1); end
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    vectors++; if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b/%b want 1/1", rdy1, rdy0); end
    tick();
  endtask

  task automatic test_pass_through();
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) drive(1'b1, 1'b1, 1'b0, 5'd3, 16'h0, 16'h0011 + 16'(k), 1'b1, 1'b0);
      else       drive(1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0);
      #3;
      if (k == 0) begin
        vectors++; if (rdy1 !== 1'b1) begin miscompares++; $display("FAIL pass_ready: got %b want 1", rdy1); end
      end else begin
        vectors++; if (v1 !== 1'b1 || wbd1 !== 16'h0010 + 16'(k)) begin miscompares++; $display("FAIL pass_data%0d: got v=%b %h want 1 %h", k, v1, wbd1, 16'h0010 + 16'(k)); end
        vectors++; if (cnt1 !== 2'd1 || wben1 !== 1'b1) begin miscompares++; $display("FAIL pass_cnt_en%0d: got %0d/%b want 1/1", k, cnt1, wben1); end
        vectors++; if (wbd0 !== 16'h0010 + 16'(k)) begin miscompares++; $display("FAIL pass_data0_%0d: got %h want %h", k, wbd0, 16'h0010 + 16'(k)); end
      end
      tick();
    end
    #3;
    vectors++; if (v1 !== 1'b0 || v0 !== 1'b0) begin miscompares++; $display("FAIL pass_drain: got %b/%b want 0/0", v1, v0); end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [15:0] seq [3];
    seq[0] = 16'hA0A0; seq[1] = 16'hB0B0; seq[2] = 16'hC0C0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, 5'd7, 16'h0, seq[k], 1'b0, 1'b0);
      #3;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, 5'd7, 16'h0, seq[2], 1'b0, 1'b0);
      #3;
      vectors++; if (cnt1 !== 2'd2 || rdy1 !== 1'b0) begin miscompares++; $display("FAIL bp_full%0d: got cnt=%0d rdy=%b want 2/0", k, cnt1, rdy1); end
      vectors++; if (wbd1 !== seq[0] || wben1 !== 1'b0) begin miscompares++; $display("FAIL bp_head%0d: got %h en=%b want %h en=0", k, wbd1, wben1, seq[0]); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(k < 2, 1'b1, 1'b0, 5'd7, 16'h0, seq[2], 1'b1, 1'b0);
      #3;
      vectors++; if (v1 !== 1'b1 || wbd1 !== seq[k]) begin miscompares++; $display("FAIL bp_order%0d: got v=%b %h want 1 %h", k, v1, wbd1, seq[k]); end
      if (k < 2) begin
        vectors++; if (rdy1 !== (k == 1)) begin miscompares++; $display("FAIL bp_ready%0d: got %b want %b", k, rdy1, (k == 1)); end
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    #3;
    tick();
  endtask

  task automatic test_mux_zero();
    drive(1'b1, 1'b1, 1'b1, 5'd5, 16'hBEEF, 16'h1234, 1'b1, 1'b0);
    #3; tick();
    drive(1'b1, 1'b1, 1'b0, 5'd0, 16'h0, 16'h0055, 1'b1, 1'b0);
    #3;
    vectors++; if (wbd1 !== 16'hBEEF || wbd0 !== 16'hBEEF) begin miscompares++; $display("FAIL mux_dmem: got %h/%h want beef", wbd1, wbd0); end
    vectors++; if (wben1 !== 1'b1) begin miscompares++; $display("FAIL mux_en: got %b want 1", wben1); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    #3;
    vectors++; if (wben1 !== 1'b0 || rw1 !== 1'b1 || wbd1 !== 16'h0055) begin miscompares++; $display("FAIL zero_reg: got en=%b rw=%b %h want 0 1 0055", wben1, rw1, wbd1); end
    vectors++; if (wben0 !== 1'b0) begin miscompares++; $display("FAIL zero_reg0: got %b want 0", wben0); end
    tick();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, 5'd4, 16'h0, 16'h0700 + 16'(k), 1'b0, 1'b0);
      #3; tick();
    end
    drive(1'b1, 1'b1, 1'b0, 5'd4, 16'h0, 16'h0702, 1'b1, 1'b1);
    #3;
    vectors++; if (cnt1 !== 2'd2) begin miscompares++; $display("FAIL flush_pre_cnt: got %0d want 2", cnt1); end
    vectors++; if (wben1 !== 1'b0 || wben0 !== 1'b0) begin miscompares++; $display("FAIL flush_en: got %b/%b want 0/0", wben1, wben0); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    #3;
    vectors++; if (v1 !== 1'b0 || cnt1 !== 2'd0 || rdy1 !== 1'b1 || wben1 !== 1'b0) begin miscompares++; $display("FAIL flush_post: got v=%b cnt=%0d rdy=%b en=%b want 0 0 1 0", v1, cnt1, rdy1, wben1); end
    vectors++; if (v0 !== 1'b0 || cnt0 !== 2'd0) begin miscompares++; $display("FAIL flush_post0: got v=%b cnt=%0d want 0 0", v0, cnt0); end
    tick();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b1, 5'd6, 16'h0900 + 16'(k), 16'h0, 1'b0, 1'b0);
      #3; tick();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    #2;
    vectors++; if (cnt1 !== 2'd2) begin miscompares++; $display("FAIL arst_pre: got %0d want 2", cnt1); end
    rst = 1'b1;
    #1;
    vectors++; if (v1 !== 1'b0 || cnt1 !== 2'd0 || wbd1 !== 16'h0 || rw1 !== 1'b0) begin miscompares++; $display("FAIL arst_now: got v=%b cnt=%0d %h rw=%b want 0 0 0000 0", v1, cnt1, wbd1, rw1); end
    vectors++; if (v0 !== 1'b0 || wbd0 !== 16'h0) begin miscompares++; $display("FAIL arst_now0: got v=%b %h want 0 0000", v0, wbd0); end
    q1.delete();
    q0.delete();
    #1;
    rst = 1'b0;
    #1;
    vectors++; if (rdy1 !== 1'b1 || v1 !== 1'b0) begin miscompares++; $display("FAIL arst_after: got rdy=%b v=%b want 1 0", rdy1, v1); end
    tick();
  endtask

  task automatic test_skid0_throughput();
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive(1'b1, 1'b1, 1'b0, 5'd9, 16'h0, 16'h0100 + 16'(k), 1'b1, 1'b0);
      else       drive(1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0);
      #3;
      vectors++; if (rdy0 !== (k < 8)) begin miscompares++; $display("FAIL s0_ready%0d: got %b want %b", k, rdy0, (k < 8)); end
      if (k > 0) begin
        vectors++; if (v0 !== 1'b1 || wbd0 !== 16'h00FF + 16'(k)) begin miscompares++; $display("FAIL s0_data%0d: got v=%b %h want 1 %h", k, v0, wbd0, 16'h00FF + 16'(k)); end
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    #3; tick();
  endtask

  task automatic test_random();
    logic [59:0] e1, e0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
      #3;
      e1 = exp_vec(q1.size(), (q1.size() > 0) ? q1[0] : nb, 1'b1);
      e0 = exp_vec(q0.size(), (q0.size() > 0) ? q0[0] : nb, 1'b0);
      vectors++; if (act1 !== e1) begin miscompares++; $display("FAIL rand_skid cyc%0d: got %h want %h", i, act1, e1); end
      vectors++; if (act0 !== e0) begin miscompares++; $display("FAIL rand_single cyc%0d: got %h want %h", i, act0, e0); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_back_pressure();
    test_mux_zero();
    test_flush();
    test_async_reset();
    test_skid0_throughput();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
